tt_lq_retire: RTL and testbench
===============================

Name: tt_lq_retire

Overview:
- Response side of the memory request skid buffer. Request-side pipeline allocates a load-queue (LQ) entry, gets back an lqid, and that lqid travels with the memory request.
- This block accepts out-of-order memory responses tagged with lqid, formats load data by size/offset, and retires entries in allocation order.
- Retirement produces an integer or FP register-file writeback, with backpressure from the writeback port.

Parameters:
- LQ_DEPTH, 8: number of LQ entries; power of 2, >=2.
- LQ_DEPTH_LOG2, $clog2(LQ_DEPTH): lqid width.

Ports:
- i_clk  input  1  clock
- i_reset  input  1  asynchronous active-high reset
- i_flush  input  1  discard all entries; synchronous
- i_alloc_vld  input  1  allocation request
- o_alloc_rdy  output  1  entry available
- o_alloc_lqid  output  LQ_DEPTH_LOG2  lqid given to the current allocation
- i_alloc_load  input  1  entry awaits a memory response (0 = ordering-only entry)
- i_alloc_rf_wr  input  1  retire writes integer RF
- i_alloc_fp_wr  input  1  retire writes FP RF
- i_alloc_rd  input  5  destination register
- i_alloc_sz  input  3  RISC-V load funct3 (0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU)
- i_alloc_addr_lo  input  2  address bits [1:0]
- i_resp_vld  input  1  memory response valid; always accepted
- i_resp_lqid  input  LQ_DEPTH_LOG2  response tag
- i_resp_data  input  32  raw aligned word
- o_stray_resp  output  1  pulse: response hit an entry not in WAIT
- o_wb_vld  output  1  head entry retiring
- i_wb_rdy  input  1  writeback accepted
- o_wb_rf_wr  output  1  integer RF write enable qualifier
- o_wb_fp_wr  output  1  FP RF write enable qualifier
- o_wb_rd  output  5  destination register
- o_wb_data  output  32  formatted load data (0 for non-load entries)
- o_empty  output  1  no entries allocated

Behaviour:
- Per-entry state: FREE, WAIT, DONE.
- Pointers: wr_ptr and rd_ptr, each LQ_DEPTH_LOG2+1 bits (MSB is the wrap bit).
  - full: indices equal, wrap bits differ.
  - empty: pointers equal.
- Reset (async): all entries FREE, pointers 0. Outputs: o_alloc_rdy=1, o_alloc_lqid=0, o_empty=1, o_wb_vld=0, o_stray_resp=0, o_wb_* data/rd/flags 0.
- Allocation:
  - Occurs on i_alloc_vld & o_alloc_rdy.
  - o_alloc_rdy = !full, computed from registered state only. No same-cycle reuse of an entry freed by a retire.
  - o_alloc_lqid = wr_ptr index.
  - Entry goes to WAIT if i_alloc_load, else DONE with data 0. wr_ptr increments and wraps.
- Response:
  - If the entry at i_resp_lqid is WAIT: store formatted data, entry goes to DONE next cycle.
  - Otherwise: no state change, o_stray_resp=1 for one cycle (registered, next cycle).
- Formatting: byte/half selected by addr_lo (half uses addr_lo[1]).
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: word unchanged.
  - Any other sz: word unchanged.
- Retire:
  - o_wb_vld = head entry in DONE and !empty; combinational from registered state.
  - On o_wb_vld & i_wb_rdy: head entry goes to FREE and rd_ptr increments.
  - While o_wb_vld=1 and i_wb_rdy=0, o_wb_* stay stable.
- Latency:
  - Response in cycle N -> o_wb_vld in cycle N+1 at earliest, if the entry is at head.
  - Non-load alloc in cycle N -> o_wb_vld at N+1 at earliest.
- Simultaneous events:
  - Alloc, response and retire in one cycle are all honoured independently.
  - A response to the head entry in the same cycle that head retires is impossible (head must already be DONE), so it is flagged stray.
- Flush:
  - Next cycle: all entries FREE, pointers 0, o_wb_vld=0.
  - Same-cycle alloc, response and retire are ignored.
  - Responses arriving after a flush are stray.

Optional Feature:
- Macro: TT_LQ_RESP_BYPASS_EN.
- Defined: if i_resp_vld targets the head entry in WAIT, o_wb_vld=1 in the same cycle with the formatted i_resp_data (combinational bypass).
  - If i_wb_rdy=1: the entry retires directly to FREE, skipping DONE.
  - If i_wb_rdy=0: the entry goes to DONE and retires later.
- Not defined: no bypass; minimum response-to-writeback latency is 1 cycle.

Test Plan:
- Reset, then alloc 8 loads: lqids 0..7, o_alloc_rdy=0 after the 8th. A 9th i_alloc_vld is not accepted.
- Alloc loads lqid0 (LB, addr_lo=3) and lqid1 (LHU, addr_lo=2). Respond lqid1 data 0x8123_0000 first, then lqid0 data 0x80FF_FFFF.
  - Writeback order is lqid0 then lqid1.
  - lqid0 data = 0xFFFF_FF80; lqid1 data = 0x0000_8123.
- Alloc non-load with rf_wr=1, rd=5: o_wb_vld next cycle, o_wb_data=0, o_wb_rd=5.
- Hold i_wb_rdy=0 for 5 cycles with DONE head: o_wb_* stable. Release: retire, rd_ptr advances.
- Response to a FREE lqid: o_stray_resp pulses 1 cycle, no writeback.
- Fill queue, wrap pointers twice with random response order, then i_flush with 3 entries pending:
  - o_empty=1 next cycle.
  - A late response to an old lqid is stray.
  - Next alloc returns lqid 0.

Source files
------------

// File: rtl/tt_lq_retire.sv
// Load-queue response/retire block: tags out-of-order memory responses by lqid, formats load
// data, retires in allocation order. Define TT_LQ_RESP_BYPASS_EN for same-cycle response bypass.
module tt_lq_retire #(
  parameter int unsigned LQ_DEPTH      = 8,
  parameter int unsigned LQ_DEPTH_LOG2 = $clog2(LQ_DEPTH)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_flush,
  input  logic                     i_alloc_vld,
  output logic                     o_alloc_rdy,
  output logic [LQ_DEPTH_LOG2-1:0] o_alloc_lqid,
  input  logic                     i_alloc_load,
  input  logic                     i_alloc_rf_wr,
  input  logic                     i_alloc_fp_wr,
  input  logic [4:0]               i_alloc_rd,
  input  logic [2:0]               i_alloc_sz,
  input  logic [1:0]               i_alloc_addr_lo,
  input  logic                     i_resp_vld,
  input  logic [LQ_DEPTH_LOG2-1:0] i_resp_lqid,
  input  logic [31:0]              i_resp_data,
  output logic                     o_stray_resp,
  output logic                     o_wb_vld,
  input  logic                     i_wb_rdy,
  output logic                     o_wb_rf_wr,
  output logic                     o_wb_fp_wr,
  output logic [4:0]               o_wb_rd,
  output logic [31:0]              o_wb_data,
  output logic                     o_empty
);

  localparam int unsigned AW = LQ_DEPTH_LOG2;

  typedef logic [AW:0]   ptr_t;
  typedef logic [AW-1:0] idx_t;
  typedef enum logic [1:0] {StFree = 2'd0, StWait = 2'd1, StDone = 2'd2} ent_st_e;

  ent_st_e     st_q    [LQ_DEPTH];
  ent_st_e     st_d    [LQ_DEPTH];
  logic [31:0] data_q  [LQ_DEPTH];
  logic        rf_wr_q [LQ_DEPTH];
  logic        fp_wr_q [LQ_DEPTH];
  logic [4:0]  rd_q    [LQ_DEPTH];
  logic [2:0]  sz_q    [LQ_DEPTH];
  logic [1:0]  lo_q    [LQ_DEPTH];

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  logic stray_q, stray_d;

  idx_t        wr_idx, rd_idx;
  logic        full, empty;
  logic        alloc_fire, resp_hit, byp, wb_vld, retire;
  logic [31:0] resp_fmt;

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] sz,
                                           input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (sz)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd4:    r = {24'b0, b};
      3'd5:    r = {16'b0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign wr_idx     = wr_ptr_q[AW-1:0];
  assign rd_idx     = rd_ptr_q[AW-1:0];
  assign full       = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign alloc_fire = i_alloc_vld && !full;
  assign resp_hit   = i_resp_vld && (st_q[i_resp_lqid] == StWait);
  assign resp_fmt   = fmt_load(i_resp_data, sz_q[i_resp_lqid], lo_q[i_resp_lqid]);

`ifdef TT_LQ_RESP_BYPASS_EN
  // A WAIT head is necessarily allocated, so no separate empty qualifier is needed.
  assign byp = resp_hit && (i_resp_lqid == rd_idx);
`else
  assign byp = 1'b0;
`endif

  assign wb_vld = (!empty && (st_q[rd_idx] == StDone)) || byp;
  assign retire = wb_vld && i_wb_rdy;

  assign o_alloc_rdy  = !full;
  assign o_alloc_lqid = wr_idx;
  assign o_empty      = empty;
  assign o_stray_resp = stray_q;
  assign o_wb_vld     = wb_vld;
  assign o_wb_rf_wr   = wb_vld ? rf_wr_q[rd_idx] : 1'b0;
  assign o_wb_fp_wr   = wb_vld ? fp_wr_q[rd_idx] : 1'b0;
  assign o_wb_rd      = wb_vld ? rd_q[rd_idx] : 5'd0;
  assign o_wb_data    = !wb_vld ? 32'd0 : (byp ? resp_fmt : data_q[rd_idx]);

  always_comb begin
    for (int i = 0; i < int'(LQ_DEPTH); i++) begin
      st_d[i] = st_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    stray_d  = i_resp_vld && !resp_hit;
    if (i_flush) begin
      for (int i = 0; i < int'(LQ_DEPTH); i++) begin
        st_d[i] = StFree;
      end
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (alloc_fire) begin
        st_d[wr_idx] = i_alloc_load ? StWait : StDone;
        wr_ptr_d     = wr_ptr_q + ptr_t'(1);
      end
      if (resp_hit) begin
        st_d[i_resp_lqid] = (byp && i_wb_rdy) ? StFree : StDone;
      end
      if (retire) begin
        st_d[rd_idx] = StFree;
        rd_ptr_d     = rd_ptr_q + ptr_t'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < int'(LQ_DEPTH); i++) begin
        st_q[i] <= StFree;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      stray_q  <= 1'b0;
    end else begin
      for (int i = 0; i < int'(LQ_DEPTH); i++) begin
        st_q[i] <= st_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      stray_q  <= stray_d;
    end
  end

  // Payload is only meaningful while the entry is not FREE, so writes need no state qualifier.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < int'(LQ_DEPTH); i++) begin
        data_q[i]  <= '0;
        rf_wr_q[i] <= 1'b0;
        fp_wr_q[i] <= 1'b0;
        rd_q[i]    <= '0;
        sz_q[i]    <= '0;
        lo_q[i]    <= '0;
      end
    end else if (!i_flush) begin
      if (alloc_fire) begin
        data_q[wr_idx]  <= '0;
        rf_wr_q[wr_idx] <= i_alloc_rf_wr;
        fp_wr_q[wr_idx] <= i_alloc_fp_wr;
        rd_q[wr_idx]    <= i_alloc_rd;
        sz_q[wr_idx]    <= i_alloc_sz;
        lo_q[wr_idx]    <= i_alloc_addr_lo;
      end
      if (resp_hit) begin
        data_q[i_resp_lqid] <= resp_fmt;
      end
    end
  end

endmodule

// File: tb/tb_tt_lq_retire.sv
// Scoreboard bench for tt_lq_retire: writebacks popped in allocation order and compared.
module tb_tt_lq_retire;

  logic        clk = 1'b0;
  logic        i_reset, i_flush;
  logic        i_alloc_vld, o_alloc_rdy;
  logic [2:0]  o_alloc_lqid;
  logic        i_alloc_load, i_alloc_rf_wr, i_alloc_fp_wr;
  logic [4:0]  i_alloc_rd;
  logic [2:0]  i_alloc_sz;
  logic [1:0]  i_alloc_addr_lo;
  logic        i_resp_vld;
  logic [2:0]  i_resp_lqid;
  logic [31:0] i_resp_data;
  logic        o_stray_resp, o_wb_vld, i_wb_rdy, o_wb_rf_wr, o_wb_fp_wr;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        o_empty;

  tt_lq_retire #(.LQ_DEPTH(8)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_flush        (i_flush),
    .i_alloc_vld    (i_alloc_vld),
    .o_alloc_rdy    (o_alloc_rdy),
    .o_alloc_lqid   (o_alloc_lqid),
    .i_alloc_load   (i_alloc_load),
    .i_alloc_rf_wr  (i_alloc_rf_wr),
    .i_alloc_fp_wr  (i_alloc_fp_wr),
    .i_alloc_rd     (i_alloc_rd),
    .i_alloc_sz     (i_alloc_sz),
    .i_alloc_addr_lo(i_alloc_addr_lo),
    .i_resp_vld     (i_resp_vld),
    .i_resp_lqid    (i_resp_lqid),
    .i_resp_data    (i_resp_data),
    .o_stray_resp   (o_stray_resp),
    .o_wb_vld       (o_wb_vld),
    .i_wb_rdy       (i_wb_rdy),
    .o_wb_rf_wr     (o_wb_rf_wr),
    .o_wb_fp_wr     (o_wb_fp_wr),
    .o_wb_rd        (o_wb_rd),
    .o_wb_data      (o_wb_data),
    .o_empty        (o_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] lqid;
    logic       rf;
    logic       fp;
    logic [4:0] rd;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] exp_data [8];
  logic        exp_rdy  [8];
  logic        pend     [8];
  logic [2:0]  m_sz     [8];
  logic [1:0]  m_lo     [8];
  logic [2:0]  nxt_id;
  int          n_checks = 0;
  int          n_err    = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_fmt(input logic [31:0] w, input logic [2:0] sz,
                                            input logic [1:0] lo);
    int          bi, hi;
    logic [7:0]  b;
    logic [15:0] h;
    bi = int'(lo) * 8;
    hi = (lo >= 2'd2) ? 16 : 0;
    b  = w[bi +: 8];
    h  = w[hi +: 16];
    if (sz == 3'd0) return {{24{b[7]}}, b};
    if (sz == 3'd1) return {{16{h[15]}}, h};
    if (sz == 3'd4) return {24'h0, b};
    if (sz == 3'd5) return {16'h0, h};
    return w;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic ld, input logic rf, input logic fp, input logic [4:0] rd,
                          input logic [2:0] sz, input logic [1:0] lo);
    sb_t e;
    i_alloc_vld = 1'b1; i_alloc_load = ld; i_alloc_rf_wr = rf; i_alloc_fp_wr = fp;
    i_alloc_rd = rd; i_alloc_sz = sz; i_alloc_addr_lo = lo;
    check_eq("alloc_rdy", 32'(o_alloc_rdy), 32'd1);
    check_eq("alloc_lqid", 32'(o_alloc_lqid), 32'(nxt_id));
    e = '{lqid: nxt_id, rf: rf, fp: fp, rd: rd};
    sb_q.push_back(e);
    m_sz[nxt_id] = sz;
    m_lo[nxt_id] = lo;
    if (ld) begin
      pend[nxt_id] = 1'b1; exp_rdy[nxt_id] = 1'b0;
    end else begin
      pend[nxt_id] = 1'b0; exp_rdy[nxt_id] = 1'b1; exp_data[nxt_id] = 32'd0;
    end
    nxt_id = nxt_id + 3'd1;
    cyc();
    i_alloc_vld = 1'b0;
  endtask

  task automatic do_resp(input logic [2:0] id, input logic [31:0] d);
    i_resp_vld = 1'b1; i_resp_lqid = id; i_resp_data = d;
    if (pend[id]) begin
      exp_data[id] = model_fmt(d, m_sz[id], m_lo[id]);
      exp_rdy[id]  = 1'b1;
      pend[id]     = 1'b0;
    end
    cyc();
    i_resp_vld = 1'b0;
  endtask

  task automatic drain();
    i_wb_rdy = 1'b1;
    for (int i = 0; i < 40 && !o_empty; i++) cyc();
    check_eq("drain_empty", 32'(o_empty), 32'd1);
  endtask

  task automatic round(input logic try_ninth);
    logic [2:0] ids [8];
    logic [2:0] t;
    int         j;
    logic [2:0] szs [7];
    szs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
    for (int i = 0; i < 8; i++) begin
      ids[i] = nxt_id;
      i_wb_rdy = 1'($urandom_range(0, 1));
      do_alloc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), szs[$urandom_range(0, 6)], 2'($urandom_range(0, 3)));
    end
    check_eq("full_rdy", 32'(o_alloc_rdy), 32'd0);
    check_eq("full_nonempty", 32'(o_empty), 32'd0);
    if (try_ninth) begin
      i_alloc_vld = 1'b1;
      cyc();
      i_alloc_vld = 1'b0;
      check_eq("ninth_rdy", 32'(o_alloc_rdy), 32'd0);
      check_eq("ninth_lqid", 32'(o_alloc_lqid), 32'(nxt_id));
    end
    for (int i = 7; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = ids[i]; ids[i] = ids[j]; ids[j] = t;
    end
    for (int i = 0; i < 8; i++) begin
      i_wb_rdy = 1'($urandom_range(0, 1));
      do_resp(ids[i], $urandom);
    end
    drain();
  endtask

  // Scoreboard pop: every accepted writeback must match the oldest outstanding allocation.
  always @(negedge clk) begin
    if (!i_reset && !i_flush && o_wb_vld && i_wb_rdy) begin
      if (sb_q.size() == 0) begin
        check_eq("wb_extra_sb_size", 32'(sb_q.size()), 32'd1);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check_eq("wb_ready", 32'(exp_rdy[e.lqid]), 32'd1);
        check_eq("wb_data", o_wb_data, exp_data[e.lqid]);
        check_eq("wb_ctl", 32'({o_wb_rf_wr, o_wb_fp_wr, o_wb_rd}), 32'({e.rf, e.fp, e.rd}));
        exp_rdy[e.lqid] = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] old_id;
    i_reset = 1'b1; i_flush = 1'b0; i_alloc_vld = 1'b0; i_alloc_load = 1'b0;
    i_alloc_rf_wr = 1'b0; i_alloc_fp_wr = 1'b0; i_alloc_rd = '0; i_alloc_sz = '0;
    i_alloc_addr_lo = '0; i_resp_vld = 1'b0; i_resp_lqid = '0; i_resp_data = '0;
    i_wb_rdy = 1'b1; nxt_id = '0;
    for (int i = 0; i < 8; i++) begin
      exp_data[i] = '0; exp_rdy[i] = 1'b0; pend[i] = 1'b0; m_sz[i] = '0; m_lo[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_alloc_rdy", 32'(o_alloc_rdy), 32'd1);
    check_eq("rst_alloc_lqid", 32'(o_alloc_lqid), 32'd0);
    check_eq("rst_empty", 32'(o_empty), 32'd1);
    check_eq("rst_wb_vld", 32'(o_wb_vld), 32'd0);
    check_eq("rst_stray", 32'(o_stray_resp), 32'd0);
    check_eq("rst_wb_fields", 32'({o_wb_rf_wr, o_wb_fp_wr, o_wb_rd}), 32'd0);
    check_eq("rst_wb_data", o_wb_data, 32'd0);
    i_reset = 1'b0;
    cyc();

    round(1'b1);

    // Out-of-order responses, in-order writeback, sign/zero extension.
    i_wb_rdy = 1'b1;
    do_alloc(1'b1, 1'b1, 1'b0, 5'd10, 3'd0, 2'd3);
    do_alloc(1'b1, 1'b1, 1'b0, 5'd11, 3'd5, 2'd2);
    do_resp(3'd1, 32'h8123_0000);
    check_eq("ooo_head_blocked", 32'(o_wb_vld), 32'd0);
    check_eq("ooo_no_stray", 32'(o_stray_resp), 32'd0);
    do_resp(3'd0, 32'h80FF_FFFF);
    check_eq("lb_vld", 32'(o_wb_vld), 32'd1);
    check_eq("lb_data", o_wb_data, 32'hFFFF_FF80);
    check_eq("lb_rd", 32'(o_wb_rd), 32'd10);
    cyc();
    check_eq("lhu_data", o_wb_data, 32'h0000_8123);
    check_eq("lhu_rd", 32'(o_wb_rd), 32'd11);
    cyc();
    check_eq("ooo_empty", 32'(o_empty), 32'd1);

    // Ordering-only entry retires the next cycle with zero data.
    do_alloc(1'b0, 1'b1, 1'b0, 5'd5, 3'd2, 2'd0);
    check_eq("nl_vld", 32'(o_wb_vld), 32'd1);
    check_eq("nl_data", o_wb_data, 32'd0);
    check_eq("nl_rd", 32'(o_wb_rd), 32'd5);
    check_eq("nl_rf", 32'(o_wb_rf_wr), 32'd1);
    cyc();
    check_eq("nl_empty", 32'(o_empty), 32'd1);

    // Backpressure hold.
    i_wb_rdy = 1'b0;
    do_alloc(1'b1, 1'b0, 1'b1, 5'd9, 3'd2, 2'd1);
    do_resp(3'd3, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_vld", 32'(o_wb_vld), 32'd1);
      check_eq("hold_data", o_wb_data, 32'hDEAD_BEEF);
      check_eq("hold_ctl", 32'({o_wb_rf_wr, o_wb_fp_wr, o_wb_rd}), 32'({1'b0, 1'b1, 5'd9}));
      cyc();
    end
    i_wb_rdy = 1'b1;
    cyc();
    check_eq("hold_released_empty", 32'(o_empty), 32'd1);
    check_eq("hold_released_lqid", 32'(o_alloc_lqid), 32'd4);

    // Stray response to a FREE entry.
    do_resp(3'd6, 32'h1234_5678);
    check_eq("stray_pulse", 32'(o_stray_resp), 32'd1);
    check_eq("stray_no_wb", 32'(o_wb_vld), 32'd0);
    cyc();
    check_eq("stray_one_cycle", 32'(o_stray_resp), 32'd0);

    round(1'b0);
    round(1'b0);
    round(1'b0);

    // Flush with three pending loads.
    i_wb_rdy = 1'b1;
    old_id = nxt_id;
    for (int i = 0; i < 3; i++) do_alloc(1'b1, 1'b1, 1'b0, 5'(i + 20), 3'd2, 2'd0);
    i_flush = 1'b1;
    cyc();
    i_flush = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 8; i++) begin
      pend[i] = 1'b0; exp_rdy[i] = 1'b0;
    end
    nxt_id = '0;
    check_eq("flush_empty", 32'(o_empty), 32'd1);
    check_eq("flush_wb_vld", 32'(o_wb_vld), 32'd0);
    check_eq("flush_lqid", 32'(o_alloc_lqid), 32'd0);
    do_resp(old_id + 3'd1, 32'hCAFE_F00D);
    check_eq("late_stray", 32'(o_stray_resp), 32'd1);
    do_alloc(1'b1, 1'b1, 1'b0, 5'd7, 3'd4, 2'd1);
    do_resp(3'd0, 32'h0000_A500);
    check_eq("post_flush_data", o_wb_data, 32'h0000_00A5);
    drain();
    check_eq("sb_left", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
